shared_select_arbiter: RTL

Shares one pipelined select unit between NUM_REQ dataflow requesters. Each requester presents a pre-joined operand bundle (condition, trueValue, falseValue). The block grants at most one bundle per cycle, round-robin, and drives the external unit. It tracks the in-flight requester ID through a fixed-latency tag pipeline and steers each result into that requester's output buffer. Per-requester credit counters guarantee the buffers never overflow, so the shared unit needs no backpressure.

---
 rtl/shared_select_arbiter_pkg.sv | 22 ++
 rtl/shared_select_arbiter_if.sv | 36 +++
 rtl/shared_select_arbiter_result_fifo.sv | 63 ++++++
 rtl/shared_select_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/shared_select_arbiter_pkg.sv
// Shared select arbiter: common types and helpers.
// Tag width is sized for the largest supported requester count.
package select_share_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int MAX_REQ = 16;
  localparam int ID_W    = clog2(MAX_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/shared_select_arbiter_if.sv
// Shared select arbiter: requester, unit and consumer bundle.
// master drives requests/results, slave is the arbiter.
interface shared_select_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_TYPE = 32
);
  logic [NUM_REQ-1:0]           ins_cond;
  logic [NUM_REQ*DATA_TYPE-1:0] ins_true;
  logic [NUM_REQ*DATA_TYPE-1:0] ins_false;
  logic [NUM_REQ-1:0]           ins_valid;
  logic [NUM_REQ-1:0]           ins_ready;
  logic                         unit_cond;
  logic [DATA_TYPE-1:0]         unit_true;
  logic [DATA_TYPE-1:0]         unit_false;
  logic                         unit_valid;
  logic [DATA_TYPE-1:0]         unit_result;
  logic [NUM_REQ*DATA_TYPE-1:0] outs;
  logic [NUM_REQ-1:0]           outs_valid;
  logic [NUM_REQ-1:0]           outs_ready;

  modport master (
    output ins_cond, ins_true, ins_false,
    output ins_valid, unit_result, outs_ready,
    input  ins_ready, unit_cond, unit_true,
    input  unit_false, unit_valid,
    input  outs, outs_valid
  );

  modport slave (
    input  ins_cond, ins_true, ins_false,
    input  ins_valid, unit_result, outs_ready,
    output ins_ready, unit_cond, unit_true,
    output unit_false, unit_valid,
    output outs, outs_valid
  );
endinterface

// File: rtl/shared_select_arbiter_result_fifo.sv
// Per-requester result buffer: circular FIFO.
// Head reads as zero while empty.
module result_fifo
  import select_share_pkg::*;
#(
  parameter int DATA_TYPE = 32,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_wr_en,
  input  logic [DATA_TYPE-1:0] i_wr_data,
  input  logic                 i_rd_en,
  output logic [DATA_TYPE-1:0] o_rd_data,
  output logic                 o_full,
  output logic                 o_empty
);
  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [DATA_TYPE-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 w_do_wr;
  logic                 w_do_rd;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_wr   = i_wr_en && !o_full;
  assign w_do_rd   = i_rd_en && !o_empty;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // storage write, no reset needed behind the empty gate
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr)
        r_wr_ptr <= (int'(r_wr_ptr) == DEPTH - 1) ?
                    '0 : r_wr_ptr + 1'b1;
      if (w_do_rd)
        r_rd_ptr <= (int'(r_rd_ptr) == DEPTH - 1) ?
                    '0 : r_rd_ptr + 1'b1;
      if (w_do_wr && !w_do_rd)
        r_count <= r_count + 1'b1;
      else if (w_do_rd && !w_do_wr)
        r_count <= r_count - 1'b1;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(i_wr_en && o_full));

endmodule

// File: rtl/shared_select_arbiter.sv
// Round-robin share of one pipelined select unit.
// Credits bound in-flight plus buffered results per requester.
module shared_select_arbiter
  import select_share_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_TYPE = 32,
  parameter int LATENCY   = 2,
  parameter int CREDITS   = 2
) (
  input logic clk,
  input logic reset,
  shared_select_arbiter_if.slave bus
);
  localparam int CW = clog2(CREDITS + 1);
  localparam int DW = DATA_TYPE;

  logic [NUM_REQ-1:0]    w_elig;
  logic [NUM_REQ-1:0]    w_grant;
  logic [NUM_REQ-1:0]    w_pop;
  logic [NUM_REQ-1:0]    w_wr;
  logic [NUM_REQ-1:0]    w_full;
  logic [NUM_REQ-1:0]    w_empty;
  logic [2*NUM_REQ-1:0]  w_rot;
  logic                  w_hit;
  logic [ID_W-1:0]       w_gid;
  int                    w_sum;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [CW-1:0]         r_credit [NUM_REQ];
  tag_t                  r_tag [LATENCY];
  logic [DW-1:0]         w_head [NUM_REQ];
  logic [NUM_REQ*DW-1:0] w_outs;

  // eligible: request present and buffer room left; quiet in reset
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_elig[i] = !reset && bus.ins_valid[i] &&
                  (r_credit[i] < CW'(CREDITS));
  end

  // first eligible at or after the pointer, cyclically
  always_comb begin
    w_rot = {w_elig, w_elig} >> r_rr_ptr;
    w_hit = 1'b0;
    w_gid = '0;
    w_sum = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_hit && w_rot[k]) begin
        w_hit = 1'b1;
        w_sum = int'(r_rr_ptr) + k;
        if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
        w_gid = ID_W'(w_sum);
      end
    end
  end

  assign w_grant = w_hit ? (NUM_REQ'(1) << w_gid) : '0;

  assign bus.ins_ready  = w_grant;
  assign bus.unit_valid = w_hit;
  assign bus.unit_cond  = |(bus.ins_cond & w_grant);
  assign bus.unit_true  = w_hit ?
    DW'(bus.ins_true >> (int'(w_gid) * DW)) : '0;
  assign bus.unit_false = w_hit ?
    DW'(bus.ins_false >> (int'(w_gid) * DW)) : '0;

  // pointer moves just past the winner
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_rr_ptr <= '0;
    else if (w_hit)
      r_rr_ptr <= (int'(w_gid) == NUM_REQ - 1) ?
                  '0 : w_gid + 1'b1;
  end

  // tag pipeline mirrors the unit latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_hit, id: w_gid};
      for (int s = 1; s < LATENCY; s++)
        r_tag[s] <= r_tag[s-1];
    end
  end

  // result write steering from the last tag stage
  always_comb begin
    w_wr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_wr[i] = r_tag[LATENCY-1].valid &&
                (r_tag[LATENCY-1].id == ID_W'(i));
  end

  assign w_pop = ~w_empty & bus.outs_ready;

  // credits: up on grant, down on pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_credit[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        unique case ({w_grant[i], w_pop[i]})
          2'b10:   r_credit[i] <= r_credit[i] + 1'b1;
          2'b01:   r_credit[i] <= r_credit[i] - 1'b1;
          default: r_credit[i] <= r_credit[i];
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_buf
    result_fifo #(
      .DATA_TYPE(DW),
      .DEPTH    (CREDITS)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .i_wr_en  (w_wr[i]),
      .i_wr_data(bus.unit_result),
      .i_rd_en  (w_pop[i]),
      .o_rd_data(w_head[i]),
      .o_full   (w_full[i]),
      .o_empty  (w_empty[i])
    );

    a_credit_max: assert property (
      @(posedge clk) disable iff (reset)
      r_credit[i] <= CW'(CREDITS));

    a_no_full_wr: assert property (
      @(posedge clk) disable iff (reset)
      !(w_wr[i] && w_full[i]));
  end

  // pack buffer heads onto the output bus
  always_comb begin
    w_outs = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_outs[i*DW +: DW] = w_head[i];
  end

  assign bus.outs       = w_outs;
  assign bus.outs_valid = ~w_empty;

endmodule
